aes_decrypt_ctrl: RTL
=====================

// Module: aes_decrypt_ctrl
// PURPOSE
//  Iterative AES decryption sequencer. Accepts one 128-bit ciphertext block, applies the
//  initial AddRoundKey, runs one shared decrypt_round instance NR-1 times, then applies a
//  final round without InvMixColumns, and presents the plaintext. Sits between the AXI4-Lite
//  register front end and the key-expansion store; it selects round keys by index.
// PARAMETERS
//  NR         10  number of AES rounds (10 = AES-128); round keys indexed 0..NR
//  KEY_IDX_W  4   width of key_idx; must satisfy 2**KEY_IDX_W > NR
// PORTS
//  clk        in   1          single clock, all state on rising edge
//  rst_n      in   1          asynchronous, active-low reset
//  in_valid   in   1          ciphertext block offered
//  in_ready   out  1          block accepted when in_valid & in_ready
//  in_data    in   128        ciphertext block
//  key_ready  in   1          key store holds a complete, valid schedule
//  key_idx    out  KEY_IDX_W  round-key index requested this cycle
//  round_key  in   128        round key for key_idx; combinational, valid in the same cycle
//  out_valid  out  1          plaintext block available
//  out_ready  in   1          consumer takes block when out_valid & out_ready
//  out_data   out  128        plaintext block (registered)
//  busy       out  1          high in every state except IDLE
// BEHAVIOUR
//  - Reset: state=IDLE, state_reg=0, round_cnt=0. Outputs: in_ready=key_ready, out_valid=0,
//    out_data=0, busy=0, key_idx=NR.
//  - IDLE: in_ready=key_ready; key_idx=NR. On accept: state_reg<=in_data^round_key,
//    round_cnt<=NR-1, go ROUND. in_valid with key_ready=0 is not accepted.
//  - ROUND: key_idx=round_cnt; state_reg<=decrypt_round(state_reg, round_key);
//    round_cnt decrements; when round_cnt==1 this cycle, go FINAL.
//  - FINAL: key_idx=0; state_reg<=AddRoundKey(InvSubBytes(InvShiftRows(state_reg)), key0);
//    go DONE.
//  - DONE: out_valid=1, out_data=state_reg. Hold both stable until out_ready. On handshake,
//    go IDLE. No new block is accepted in DONE (in_ready=0).
//  - Latency: accept edge + NR edges -> out_valid high (10 cycles for NR=10). Minimum
//    issue interval: NR+2 cycles with out_ready tied high.
//  - in_ready is asserted only in IDLE. in_data is sampled only on the accept edge.
//  - key_ready is sampled only in IDLE. The key store must not change during an operation.
//    Deassertion mid-operation is ignored and is not flagged.
//  - out_data changes only on the FINAL->DONE edge. It is not forced to zero in other states;
//    consumers qualify with out_valid.
//  - Reset asserted mid-operation: immediate return to reset values. The partial block is
//    discarded and no out_valid pulse occurs.
//  - Illegal state encoding: returns to IDLE on the next edge.
// STRUCTURE
//  - Shared include aes_defines.vh: AES_BLOCK_W=128, state encodings (IDLE, ROUND, FINAL,
//    DONE), and the default NR for AES-128.
//  - One decrypt_round instance, used every ROUND cycle.
//  - One sub-module, dec_final_round: inv_shift_rows -> inv_subBytes -> addRoundKey, with
//    no InvMixColumns.
//  - The initial AddRoundKey is an inline XOR on the accept path.
// TESTING
//  Bench models the key store from FIPS-197 key 000102030405060708090a0b0c0d0e0f
//  (combinational lookup on key_idx).
//  1. FIPS-197 C.1: in_data=69c4e0d86a7b0430d8cdb78070b4c55a, out_ready=1
//     -> out_data=00112233445566778899aabbccddeeff; out_valid exactly 10 cycles after accept.
//  2. Backpressure: out_ready=0 for 20 cycles after out_valid -> out_valid and out_data held;
//     in_ready=0 throughout; one handshake, then IDLE.
//  3. Back-to-back: 4 blocks offered continuously, out_ready=1 -> each accepted 12 cycles
//     apart; outputs match the reference model in order.
//  4. key_ready=0 with in_valid=1 for 5 cycles -> no accept, busy=0; key_ready=1 -> accept
//     on that cycle.
//  5. rst_n pulsed low in ROUND (round_cnt=5) -> all outputs at reset values immediately;
//     the next block decrypts correctly.
//  6. key_idx trace for one block -> 10,9,8,...,1,0 on consecutive cycles from accept
//     through FINAL.

Source files
------------

// File: rtl/aes_decrypt_ctrl_pkg.sv
// Shared AES decrypt types, state encodings and inverse-cipher byte transforms.
// Latency: none; everything here is combinational helpers and constants.
// Backpressure: not applicable.
package aes_decrypt_ctrl_pkg;

    localparam int AES_BLOCK_W = 128;
    localparam int AES128_NR   = 10;

    typedef logic [AES_BLOCK_W-1:0] aes_block_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_FINAL = 2'd2,
        ST_DONE  = 2'd3
    } dec_state_e;

    // Inverse S-box, indexed by the substituted byte value.
    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gf_xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiply by a small constant k (only 4-bit constants are needed here).
    function automatic logic [7:0] gf_mul_c(input logic [7:0] a, input logic [3:0] k);
        logic [7:0] a2;
        logic [7:0] a4;
        logic [7:0] a8;
        a2 = gf_xtime(a);
        a4 = gf_xtime(a2);
        a8 = gf_xtime(a4);
        return ({8{k[0]}} & a) ^ ({8{k[1]}} & a2) ^ ({8{k[2]}} & a4) ^ ({8{k[3]}} & a8);
    endfunction

    // Byte k of the block is bits [127-8k -: 8]; state is column-major (k = 4*col + row).
    // Row r is rotated right by r columns.
    function automatic aes_block_t inv_shift_rows(input aes_block_t s);
        aes_block_t r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                r[AES_BLOCK_W-1-8*(4*c+row) -: 8] = s[AES_BLOCK_W-1-8*(4*((c+4-row)%4)+row) -: 8];
            end
        end
        return r;
    endfunction

    function automatic aes_block_t inv_sub_bytes(input aes_block_t s);
        aes_block_t r;
        r = '0;
        for (int k = 0; k < AES_BLOCK_W/8; k++) begin
            r[8*k +: 8] = INV_SBOX[s[8*k +: 8]];
        end
        return r;
    endfunction

    // Each column is multiplied by the fixed polynomial {0b}x^3+{0d}x^2+{09}x+{0e}.
    function automatic aes_block_t inv_mix_columns(input aes_block_t s);
        aes_block_t r;
        logic [7:0] a0, a1, a2, a3;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[AES_BLOCK_W-1-32*c  -: 8];
            a1 = s[AES_BLOCK_W-9-32*c  -: 8];
            a2 = s[AES_BLOCK_W-17-32*c -: 8];
            a3 = s[AES_BLOCK_W-25-32*c -: 8];
            r[AES_BLOCK_W-1-32*c  -: 8] = gf_mul_c(a0, 4'he) ^ gf_mul_c(a1, 4'hb) ^ gf_mul_c(a2, 4'hd) ^ gf_mul_c(a3, 4'h9);
            r[AES_BLOCK_W-9-32*c  -: 8] = gf_mul_c(a0, 4'h9) ^ gf_mul_c(a1, 4'he) ^ gf_mul_c(a2, 4'hb) ^ gf_mul_c(a3, 4'hd);
            r[AES_BLOCK_W-17-32*c -: 8] = gf_mul_c(a0, 4'hd) ^ gf_mul_c(a1, 4'h9) ^ gf_mul_c(a2, 4'he) ^ gf_mul_c(a3, 4'hb);
            r[AES_BLOCK_W-25-32*c -: 8] = gf_mul_c(a0, 4'hb) ^ gf_mul_c(a1, 4'hd) ^ gf_mul_c(a2, 4'h9) ^ gf_mul_c(a3, 4'he);
        end
        return r;
    endfunction

endpackage

// File: rtl/aes_decrypt_ctrl_round.sv
// Combinational AES inverse round datapaths: full middle round and final round.
// Latency: zero cycles, pure logic between the sequencer's state registers.
// Backpressure: none; the sequencer decides when results are captured.
module decrypt_round
    import aes_decrypt_ctrl_pkg::*;
(
    input  logic [AES_BLOCK_W-1:0] state_i,
    input  logic [AES_BLOCK_W-1:0] round_key_i,
    output logic [AES_BLOCK_W-1:0] state_o
);

    // Middle round: InvShiftRows, InvSubBytes, AddRoundKey, then InvMixColumns.
    assign state_o = inv_mix_columns(inv_sub_bytes(inv_shift_rows(state_i)) ^ round_key_i);

endmodule

// Last round of the inverse cipher; identical to a middle round minus InvMixColumns.
module dec_final_round
    import aes_decrypt_ctrl_pkg::*;
(
    input  logic [AES_BLOCK_W-1:0] state_i,
    input  logic [AES_BLOCK_W-1:0] round_key_i,
    output logic [AES_BLOCK_W-1:0] state_o
);

    // Final round: InvShiftRows, InvSubBytes, AddRoundKey with round key 0.
    assign state_o = inv_sub_bytes(inv_shift_rows(state_i)) ^ round_key_i;

endmodule

// File: rtl/aes_decrypt_ctrl.sv
// Iterative AES block decryptor: one shared inverse round reused NR-1 times, then a final round.
// Latency: accept edge + NR edges to out_valid; one block in flight, issue interval NR+2.
// Backpressure: in_ready only in IDLE with key_ready; result held in DONE until out_ready.
module aes_decrypt_ctrl
    import aes_decrypt_ctrl_pkg::*;
#(
    parameter int NR        = AES128_NR,
    parameter int KEY_IDX_W = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_BLOCK_W-1:0] in_data,
    input  logic                   key_ready,
    output logic [KEY_IDX_W-1:0]   key_idx,
    input  logic [AES_BLOCK_W-1:0] round_key,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_BLOCK_W-1:0] out_data,
    output logic                   busy
);

    // Key index used while idle is the last round key, needed by the initial AddRoundKey.
    localparam logic [KEY_IDX_W-1:0] KEY_LAST  = KEY_IDX_W'(NR);
    localparam logic [KEY_IDX_W-1:0] CNT_START = KEY_IDX_W'(NR - 1);
    localparam logic [KEY_IDX_W-1:0] CNT_ONE   = KEY_IDX_W'(1);

    dec_state_e             state_q;
    logic [AES_BLOCK_W-1:0] blk_q;
    logic [AES_BLOCK_W-1:0] blk_d;
    logic [KEY_IDX_W-1:0]   cnt_q;
    logic [AES_BLOCK_W-1:0] out_q;
    logic                   out_vld_q;

    logic [AES_BLOCK_W-1:0] round_out;
    logic [AES_BLOCK_W-1:0] final_out;
    logic                   accept;

    decrypt_round u_round (
        .state_i     (blk_q),
        .round_key_i (round_key),
        .state_o     (round_out)
    );

    dec_final_round u_final (
        .state_i     (blk_q),
        .round_key_i (round_key),
        .state_o     (final_out)
    );

    assign in_ready  = (state_q == ST_IDLE) && key_ready;
    assign accept    = in_ready && in_valid;
    assign busy      = (state_q != ST_IDLE);
    assign out_valid = out_vld_q;
    assign out_data  = out_q;

    // Round-key request follows the state: last key when idle, counter in rounds, key 0 at the end.
    always_comb begin
        key_idx = KEY_LAST;
        case (state_q)
            ST_IDLE:  key_idx = KEY_LAST;
            ST_ROUND: key_idx = cnt_q;
            ST_FINAL: key_idx = '0;
            default:  key_idx = KEY_LAST;
        endcase
    end

    // Next working block: initial key whitening on accept, otherwise the active round's result.
    always_comb begin
        blk_d = blk_q;
        case (state_q)
            ST_IDLE:  blk_d = accept ? (in_data ^ round_key) : blk_q;
            ST_ROUND: blk_d = round_out;
            ST_FINAL: blk_d = final_out;
            default:  blk_d = blk_q;
        endcase
    end

    // Sequencer: block capture, round countdown, result register and output handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            blk_q     <= '0;
            cnt_q     <= '0;
            out_q     <= '0;
            out_vld_q <= 1'b0;
        end else begin
            blk_q <= blk_d;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        cnt_q   <= CNT_START;
                        state_q <= ST_ROUND;
                    end
                end
                ST_ROUND: begin
                    cnt_q <= cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_q <= ST_FINAL;
                    end
                end
                ST_FINAL: begin
                    // out_data only ever changes here, so it stays stable through DONE.
                    out_q     <= final_out;
                    out_vld_q <= 1'b1;
                    state_q   <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_vld_q <= 1'b0;
                        state_q   <= ST_IDLE;
                    end
                end
                default: begin
                    out_vld_q <= 1'b0;
                    state_q   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
